i2s_rx: RTL



---
 rtl/i2s_pkg.sv | 18 +
 rtl/i2s_rx_sync.sv | 41 ++++
 rtl/i2s_rx.sv | 117 +++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants, state encoding and count-width macro for the I2S receiver
package i2s_pkg;

  localparam int I2S_DATA_WIDTH = 16;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_RUN  = 1'b1
  } i2s_state_e;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

endpackage

`ifndef I2S_CNT_W
`define I2S_CNT_W(dw) ($clog2(dw) + 1)
`endif

// File: rtl/i2s_rx_sync.sv
// rtl/i2s_rx_sync.sv - input synchronizers for sck/ws/sd plus registered sck rise detect
module i2s_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_sys_clk,
  input  logic i_sys_rst,
  input  logic i_sck,
  input  logic i_ws,
  input  logic i_sd,
  output logic sck_rise,
  output logic ws_s,
  output logic sd_s
);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ws_sync;
  logic [SYNC_STAGES-1:0] sd_sync;
  logic                   sck_prev;

  // ws/sd are taken from the same stage as the sck edge so the bit lines up with its edge
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      sck_sync <= '0;
      ws_sync  <= '0;
      sd_sync  <= '0;
      sck_prev <= 1'b0;
      sck_rise <= 1'b0;
      ws_s     <= 1'b0;
      sd_s     <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], i_sck};
      ws_sync  <= {ws_sync[SYNC_STAGES-2:0], i_ws};
      sd_sync  <= {sd_sync[SYNC_STAGES-2:0], i_sd};
      sck_prev <= sck_sync[SYNC_STAGES-1];
      sck_rise <= sck_sync[SYNC_STAGES-1] & ~sck_prev;
      ws_s     <= ws_sync[SYNC_STAGES-1];
      sd_s     <= sd_sync[SYNC_STAGES-1];
    end
  end

endmodule

// File: rtl/i2s_rx.sv
// rtl/i2s_rx.sv - I2S slave receiver (Philips framing); optional I2S_RX_NEGATE_EN negates each word
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DATA_WIDTH  = I2S_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  i_sys_clk,
  input  logic                  i_sys_rst,
  input  logic                  i_sck,
  input  logic                  i_ws,
  input  logic                  i_sd,
  output logic [DATA_WIDTH-1:0] o_left_data,
  output logic [DATA_WIDTH-1:0] o_right_data,
  output logic                  o_left_vld,
  output logic                  o_right_vld,
  output logic                  o_frame_err,
  output logic                  o_locked
);

  localparam int            CW   = `I2S_CNT_W(DATA_WIDTH);
  localparam logic [CW-1:0] FULL = CW'(DATA_WIDTH);

  logic                  sck_rise;
  logic                  ws_s;
  logic                  sd_s;
  i2s_state_e            state;
  i2s_state_e            state_nxt;
  logic                  ws_prev;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         cnt;
  logic                  transition;
  logic                  keep_bit;
  logic [DATA_WIDTH-1:0] shreg_in;
  logic [CW-1:0]         cnt_in;
  logic [DATA_WIDTH-1:0] word_just;
  logic [DATA_WIDTH-1:0] word_out;

  i2s_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_sys_clk(i_sys_clk),
    .i_sys_rst(i_sys_rst),
    .i_sck    (i_sck),
    .i_ws     (i_ws),
    .i_sd     (i_sd),
    .sck_rise (sck_rise),
    .ws_s     (ws_s),
    .sd_s     (sd_s)
  );

  // Bits beyond DATA_WIDTH are dropped; short words are left-justified at completion
  always_comb begin
    transition = (ws_s != ws_prev);
    keep_bit   = (cnt < FULL);
    shreg_in   = keep_bit ? {shreg[DATA_WIDTH-2:0], sd_s} : shreg;
    cnt_in     = keep_bit ? cnt + CW'(1) : cnt;
    word_just  = shreg_in << (FULL - cnt_in);
`ifdef I2S_RX_NEGATE_EN
    word_out   = ~word_just + DATA_WIDTH'(1);
`else
    word_out   = word_just;
`endif
  end

  always_comb begin
    state_nxt = state;
    o_locked  = (state == ST_RUN);
    if (sck_rise && (state == ST_HUNT) && transition) begin
      state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state        <= ST_HUNT;
      ws_prev      <= 1'b0;
      shreg        <= '0;
      cnt          <= '0;
      o_left_data  <= '0;
      o_right_data <= '0;
      o_left_vld   <= 1'b0;
      o_right_vld  <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      state       <= state_nxt;
      o_left_vld  <= 1'b0;
      o_right_vld <= 1'b0;
      o_frame_err <= 1'b0;
      if (sck_rise) begin
        ws_prev <= ws_s;
        if (state == ST_HUNT) begin
          if (transition) begin
            shreg <= '0;
            cnt   <= '0;
          end
        end else if (transition) begin
          // The bit arriving with the WS change is the LSB of the ws_prev channel's word
          if (ws_prev == CH_LEFT) begin
            o_left_data <= word_out;
            o_left_vld  <= 1'b1;
          end else begin
            o_right_data <= word_out;
            o_right_vld  <= 1'b1;
          end
          o_frame_err <= (cnt_in < FULL);
          shreg       <= '0;
          cnt         <= '0;
        end else begin
          shreg <= shreg_in;
          cnt   <= cnt_in;
        end
      end
    end
  end

endmodule
